// File: rtl/grant_scheduler_if.sv
// rtl/grant_scheduler_if.sv - request/grant bundle between requesters and the grant scheduler
interface grant_scheduler_if;
    logic [7:0] req;
    logic       en;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       busy;

    modport master (output req, input en, sel, gnt, busy);
    modport slave  (input req, output en, sel, gnt, busy);
endinterface

// File: rtl/grant_scheduler.sv
// rtl/grant_scheduler.sv - 8-way round-robin grant scheduler with per-ownership quantum and one-cycle gap
module grant_scheduler #(
    parameter int QUANTUM = 4
) (
    input  logic              clk,
    input  logic              rst,
    grant_scheduler_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

    state_t     r_state;
    logic [2:0] r_ptr;
    logic [2:0] r_owner;
    logic [3:0] r_cnt;
    logic       r_en;
    logic [2:0] r_sel;
    logic [7:0] r_gnt;
    logic       r_busy;

    logic       w_found;
    logic [2:0] w_winner;

    // Descending scan so the smallest offset from ptr is the last (winning) assignment.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_ptr;
        for (int k = 7; k >= 0; k--) begin
            if (bus.req[r_ptr + 3'(k)]) begin
                w_found  = 1'b1;
                w_winner = r_ptr + 3'(k);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= 3'd0;
            r_owner <= 3'd0;
            r_cnt   <= 4'd0;
            r_en    <= 1'b0;
            r_sel   <= 3'd0;
            r_gnt   <= 8'h00;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_GAP: begin
                    if (w_found) begin
                        r_state <= S_GRANT;
                        r_owner <= w_winner;
                        r_cnt   <= 4'd1;
                        r_en    <= 1'b1;
                        r_sel   <= 3'd7 - w_winner;
                        r_gnt   <= 8'b1 << w_winner;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_en    <= 1'b0;
                        r_gnt   <= 8'h00;
                        r_busy  <= 1'b0;
                    end
                end
                S_GRANT: begin
                    // Owner release and quantum expiry collapse into one exit.
                    if (!bus.req[r_owner] || r_cnt == 4'(QUANTUM)) begin
                        r_state <= S_GAP;
                        r_ptr   <= r_owner + 3'd1;
                        r_en    <= 1'b0;
                        r_gnt   <= 8'h00;
                        r_busy  <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_en    <= 1'b0;
                    r_gnt   <= 8'h00;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.en   = r_en;
    assign bus.sel  = r_sel;
    assign bus.gnt  = r_gnt;
    assign bus.busy = r_busy;
endmodule

// File: doc/grant_scheduler.md
GRANT_SCHEDULER -- requirements
Module: grant_scheduler

Interface
REQ-001 Parameter QUANTUM, default 4, maximum consecutive grant cycles per ownership; legal range 1..15.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req  input  8  request lines; req[i] high = requester i wants the shared line.
REQ-005 en   output 1  decoder enable; high only while a grant is active.
REQ-006 sel  output 3  decoder select; requester i is addressed by sel = 7 - i, matching the team 3-to-8 decoder line mapping d[7-sel].
REQ-007 gnt  output 8  one-hot grant; gnt[i] high = requester i owns the line.
REQ-008 busy output 1  high whenever state is not IDLE.

Function
REQ-009 The block SHALL implement three states: IDLE, GRANT, GAP.
REQ-010 The block SHALL hold an internal 3-bit round-robin pointer ptr, a 3-bit owner register and a 4-bit cycle counter cnt.
REQ-011 All outputs SHALL be registered; no combinational path from req to any output.
REQ-012 Winner selection SHALL be the first i with req[i]=1, scanning ascending from ptr, wrapping 7 -> 0.
REQ-013 IDLE: if any req bit is high at a rising edge, next state GRANT with owner = winner, cnt = 1; else remain IDLE.
REQ-014 Grant latency SHALL be exactly one cycle: req sampled high at edge k -> en/gnt/sel valid after edge k.
REQ-015 GRANT: en=1, gnt = one-hot(owner), sel = 7 - owner; exactly one gnt bit high.
REQ-016 GRANT exit: at an edge where req[owner]=0 or cnt = QUANTUM, next state GAP; otherwise remain GRANT and cnt increments by 1.
REQ-017 On GRANT exit, ptr SHALL become (owner + 1) mod 8; owner 7 wraps ptr to 0.
REQ-018 A grant SHALL therefore last at most QUANTUM cycles; with QUANTUM=1 every grant lasts one cycle.
REQ-019 GAP: en=0, gnt=0, sel holds last driven value; lasts exactly one cycle.
REQ-020 GAP exit: if any req high, next state GRANT with winner from updated ptr, cnt = 1; else IDLE.
REQ-021 A single persistent requester SHALL receive repeating patterns of QUANTUM grant cycles followed by one gap cycle.
REQ-022 Requests from non-owners during GRANT SHALL not preempt the owner.
REQ-023 req[owner] falling and cnt = QUANTUM on the same edge SHALL be a single exit (one GAP, one ptr update).
REQ-024 Requests arriving during GAP SHALL be considered at the GAP exit edge.
REQ-025 en and gnt SHALL never be high in IDLE or GAP.

Reset
REQ-026 rst high SHALL immediately, without a clock, force state IDLE, en=0, sel=3'b000, gnt=8'h00, busy=0, ptr=0, owner=0, cnt=0.
REQ-027 Reset asserted mid-GRANT SHALL drop en and gnt asynchronously; after release, arbitration restarts from ptr=0.
REQ-028 Release of rst SHALL take effect at the first rising edge at which rst is low; no grant is issued on that edge if req=0.

Verification
REQ-029 Reset then req=8'h00 for 10 cycles -> en=0, gnt=8'h00, sel=3'b000, busy=0 throughout.
REQ-030 QUANTUM=4, req=8'h01 held constant -> gnt=8'h01, sel=3'b111, en=1 for 4 cycles, 1 gap cycle, repeat.
REQ-031 QUANTUM=4, req=8'h81 held -> owner order 0,7,0,7; sel alternates 3'b111, 3'b000; ptr wraps 7 -> 0.
REQ-032 req=8'h24 held, req[2] dropped after 2 grant cycles -> grant to 2 ends after 2 cycles, GAP, then gnt=8'h20, sel=3'b010.
REQ-033 req=8'hFF held, QUANTUM=1 -> owners 0..7 in ascending order, each 1 cycle, 1 gap between, sel = 7,6,...,0.
REQ-034 rst pulsed mid-GRANT of owner 5 -> en, gnt fall before next clk edge; after release with req=8'h20, owner 5 granted one cycle later.
